// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller slice: controller
// state encoding, data width and a small saturating-increment helper.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } ctrlState_e;

  // Increment an 8-bit counter, sticking at 255 instead of wrapping
  function automatic logic [7:0] satInc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with a registered head. The head register always
// holds the oldest entry, so the read data is valid in the same cycle as
// "not empty". A push into a full FIFO is only taken when a pop happens in
// the same cycle; a pop from an empty FIFO is ignored.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        pushData_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wrPtr_q, wrPtr_d;
  logic [AW-1:0]     rdPtr_q, rdPtr_d;
  logic [LW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              doPush, doPop;
  logic [AW-1:0]     rdNext;

  assign doPop   = pop_i && (count_q != '0);
  assign doPush  = push_i && ((count_q != LW'(DEPTH)) || doPop);
  assign rdNext  = rdPtr_q + 1'b1;

  // Next pointers, occupancy and head value for the cycle's push/pop mix
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    head_d  = head_q;
    if (doPush) wrPtr_d = wrPtr_q + 1'b1;
    if (doPop)  rdPtr_d = rdNext;
    if (doPush && !doPop) count_d = count_q + 1'b1;
    if (doPop && !doPush) count_d = count_q - 1'b1;
    if (doPop) begin
      if (count_q == LW'(1)) begin
        if (doPush) head_d = pushData_i;
      end else begin
        head_d = mem_q[rdNext];
      end
    end else if ((count_q == '0) && doPush) begin
      head_d = pushData_i;
    end
  end

  // Storage array write port; contents need no reset
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

  // Pointer, occupancy and head registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  assign head_o  = head_q;
  assign full_o  = (count_q == LW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sequences the receiver enable (arm, run, error
// holdoff), buffers completed bytes in a FIFO exposed as a valid/ready
// stream, flags overrun and fires an idle-line tick.
// Optional statistics counters are built when UART_RX_CTRL_STATS_EN is defined.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int ERR_HOLDOFF  = 16,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  output logic                     rx_en,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     rx_done,
  input  logic                     rx_busy,
  input  logic                     rx_err,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     overrun,
  input  logic                     overrun_clr,
  output logic                     idle_tick,
`ifdef UART_RX_CTRL_STATS_EN
  output logic [15:0]              byte_cnt,
  output logic [7:0]               err_cnt,
  output logic [7:0]               drop_cnt,
`endif
  output logic [$clog2(DEPTH):0]   level
);

  localparam int HW = $clog2(ERR_HOLDOFF + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT);

  ctrlState_e    state_q, state_d;
  logic [HW-1:0] holdCnt_q, holdCnt_d;
  logic          rxEn_q, rxEn_d;
  logic          overrun_q, overrun_d;
  logic [IW-1:0] idleCnt_q, idleCnt_d;
  logic          idleArmed_q, idleArmed_d;
  logic          idleTick_q, idleTick_d;
  logic          accept, popEff, drop, pushTaken, errEvent;
  logic          fifoFull, fifoEmpty;

  assign accept    = (state_q == ST_RUN) && rx_done && !rx_err;
  assign popEff    = m_ready && !fifoEmpty;
  assign drop      = accept && fifoFull && !popEff;
  assign pushTaken = accept && !drop;
  assign errEvent  = (state_q == ST_RUN) && rx_err && enable;

  // Controller next state, holdoff countdown and receiver enable request
  always_comb begin
    state_d   = state_q;
    holdCnt_d = holdCnt_q;
    rxEn_d    = (state_q == ST_ARM) || (state_q == ST_RUN);
    case (state_q)
      ST_OFF:  if (enable) state_d = ST_ARM;
      ST_ARM:  state_d = ST_RUN;
      ST_RUN: begin
        if (rx_err) begin
          state_d   = ST_HOLD;
          holdCnt_d = HW'(ERR_HOLDOFF - 1);
        end
      end
      ST_HOLD: begin
        if (holdCnt_q == '0) state_d = ST_ARM;
        else                 holdCnt_d = holdCnt_q - 1'b1;
      end
      default: state_d = ST_OFF;
    endcase
    if (!enable) state_d = ST_OFF;
  end

  // Controller state, holdoff counter and registered receiver enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      holdCnt_q <= '0;
      rxEn_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      holdCnt_q <= holdCnt_d;
      rxEn_q    <= rxEn_d;
    end
  end

  // Overrun is sticky; a new drop beats a simultaneous clear
  always_comb begin
    overrun_d = overrun_q;
    if (drop)             overrun_d = 1'b1;
    else if (overrun_clr) overrun_d = 1'b0;
  end

  // Idle counter: counts quiet RUN cycles after a byte, ticks once, then disarms
  always_comb begin
    idleCnt_d   = idleCnt_q;
    idleArmed_d = idleArmed_q;
    idleTick_d  = 1'b0;
    if (state_q != ST_RUN) begin
      idleCnt_d = '0;
      if (state_q == ST_ARM) idleArmed_d = 1'b0;
    end else if (rx_busy || rx_done) begin
      idleCnt_d = '0;
      if (accept) idleArmed_d = 1'b1;
    end else if (idleArmed_q) begin
      if (idleCnt_q != IW'(IDLE_TIMEOUT - 1)) idleCnt_d = idleCnt_q + 1'b1;
      if (idleCnt_q == IW'(IDLE_TIMEOUT - 2)) begin
        idleTick_d  = 1'b1;
        idleArmed_d = 1'b0;
      end
    end
  end

  // Overrun flag and idle-timeout registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q   <= 1'b0;
      idleCnt_q   <= '0;
      idleArmed_q <= 1'b0;
      idleTick_q  <= 1'b0;
    end else begin
      overrun_q   <= overrun_d;
      idleCnt_q   <= idleCnt_d;
      idleArmed_q <= idleArmed_d;
      idleTick_q  <= idleTick_d;
    end
  end

  uart_sync_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (accept),
    .pushData_i (rx_data),
    .pop_i      (m_ready),
    .head_o     (m_data),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .level_o    (level)
  );

`ifdef UART_RX_CTRL_STATS_EN
  logic [15:0] byteCnt_q;
  logic [7:0]  errCnt_q, dropCnt_q;

  // Statistics: bytes stored (wrapping), error entries and drops (saturating)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byteCnt_q <= '0;
      errCnt_q  <= '0;
      dropCnt_q <= '0;
    end else begin
      if (pushTaken) byteCnt_q <= byteCnt_q + 16'd1;
      if (errEvent)  errCnt_q  <= satInc8(errCnt_q);
      if (drop)      dropCnt_q <= satInc8(dropCnt_q);
    end
  end

  assign byte_cnt = byteCnt_q;
  assign err_cnt  = errCnt_q;
  assign drop_cnt = dropCnt_q;
`else
  logic unusedStats;
  assign unusedStats = pushTaken ^ errEvent;
`endif

  assign rx_en     = rxEn_q;
  assign m_valid   = !fifoEmpty;
  assign overrun   = overrun_q;
  assign idle_tick = idleTick_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed sequencing/idle/reset scenarios plus
// randomized byte traffic, with a queue-based reference of the byte stream
// and overrun flag checked by an independent monitor.
module tb_uart_rx_ctrl;

  localparam int DEPTH   = 8;
  localparam int HOLDOFF = 16;
  localparam int IDLE    = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       rx_done = 1'b0;
  logic       rx_busy = 1'b0;
  logic       rx_err = 1'b0;
  logic       m_ready = 1'b0;
  logic       overrun_clr = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_en, m_valid, overrun, idle_tick;
  logic [7:0] m_data;
  logic [3:0] level;
`ifdef UART_RX_CTRL_STATS_EN
  logic [15:0] byte_cnt;
  logic [7:0]  err_cnt, drop_cnt;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] expQ[$];
  logic       expOverrun = 1'b0;
  bit         inRun = 1'b0;
  bit         monEn = 1'b0;
  int         expBytes = 0;
  int         expDrops = 0;
  int         expErrs = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DEPTH(DEPTH), .ERR_HOLDOFF(HOLDOFF), .IDLE_TIMEOUT(IDLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .rx_en       (rx_en),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rx_busy     (rx_busy),
    .rx_err      (rx_err),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .idle_tick   (idle_tick),
`ifdef UART_RX_CTRL_STATS_EN
    .byte_cnt    (byte_cnt),
    .err_cnt     (err_cnt),
    .drop_cnt    (drop_cnt),
`endif
    .level       (level)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus starting just after a rising edge; the reference
  // decides from the queue whether the byte is stored or dropped
  task automatic applyStimulus(input bit done, input logic [7:0] data, input bit ready,
                               input bit err, input bit clr);
    bit accepted, dropIt;
    rx_done = done; rx_data = data; m_ready = ready; rx_err = err; overrun_clr = clr;
    accepted = inRun && enable && done && !err;
    dropIt = accepted && (expQ.size() == DEPTH) && !(ready && expQ.size() > 0);
    @(posedge clk); #1;
    if (accepted && !dropIt) begin expQ.push_back(data); expBytes++; end
    if (dropIt) begin expOverrun = 1'b1; expDrops++; end
    else if (clr) expOverrun = 1'b0;
    if (inRun && enable && err) begin inRun = 1'b0; expErrs++; end
    rx_done = 1'b0; rx_err = 1'b0; overrun_clr = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  // Raise enable and confirm rx_en comes up two cycles later
  task automatic enableAndWait();
    enable = 1'b1;
    @(negedge clk); checkOutput("rx_en enable+0", rx_en, 0);
    @(posedge clk); #1;
    @(negedge clk); checkOutput("rx_en enable+1", rx_en, 0);
    @(posedge clk); #1;
    @(negedge clk); checkOutput("rx_en enable+2", rx_en, 1);
    @(posedge clk); #1;
    inRun = 1'b1;
  endtask

  // Monitor: compares occupancy, valid, overrun and every transferred byte
  always @(negedge clk) begin
    if (rst_n && monEn) begin
      checkOutput("level", level, expQ.size());
      checkOutput("m_valid", m_valid, expQ.size() != 0);
      checkOutput("overrun", overrun, expOverrun);
      if (m_valid && m_ready) begin
        if (expQ.size() == 0) checkOutput("unexpected byte", m_data, 32'hDEAD);
        else                  checkOutput("m_data", m_data, expQ.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] t1Bytes [3];
    logic       holdSeq [20];
    int         zeroRun, firstTick, tickCount;
    t1Bytes[0] = 8'h55; t1Bytes[1] = 8'hA3; t1Bytes[2] = 8'h00;

    // Reset values
    idleCycles(3);
    @(negedge clk);
    checkOutput("reset rx_en", rx_en, 0);
    checkOutput("reset m_valid", m_valid, 0);
    checkOutput("reset m_data", m_data, 0);
    checkOutput("reset level", level, 0);
    checkOutput("reset overrun", overrun, 0);
    checkOutput("reset idle_tick", idle_tick, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    monEn = 1'b1;

    // Arm sequence and three bytes with the consumer ready
    enableAndWait();
    for (int i = 0; i < 3; i++) applyStimulus(1, t1Bytes[i], 1, 0, 0);
    idleCycles(4);
    checkOutput("t1 drained", expQ.size(), 0);

    // Overflow by one, drain, clear the sticky flag
    for (int i = 1; i <= 9; i++) applyStimulus(1, 8'(i), 0, 0, 0);
    @(negedge clk);
    checkOutput("t2 level full", level, DEPTH);
    checkOutput("t2 overrun set", overrun, 1);
    @(posedge clk); #1;
    m_ready = 1'b1;
    idleCycles(10);
    applyStimulus(0, 8'h00, 1, 0, 1);
    idleCycles(2);

    // Push and pop together while full
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 8'(8'h20 + i), 0, 0, 0);
    applyStimulus(1, 8'h99, 1, 0, 0);
    m_ready = 1'b0;
    @(negedge clk);
    checkOutput("t3 level", level, DEPTH);
    checkOutput("t3 overrun", overrun, 0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    idleCycles(10);

    // Receiver error: byte in the same cycle is dropped, then holdoff
    applyStimulus(1, 8'hEE, 1, 1, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); holdSeq[i] = rx_en;
      @(posedge clk); #1;
    end
    zeroRun = 0;
    for (int i = 1; i <= 16; i++) if (holdSeq[i] == 1'b0) zeroRun++;
    checkOutput("hold rx_en first", holdSeq[0], 1);
    checkOutput("hold zero cycles", zeroRun, HOLDOFF);
    checkOutput("hold rx_en rearmed", holdSeq[17], 1);
    checkOutput("hold err byte not stored", m_valid, 0);
    inRun = 1'b1;

    // Idle timeout after one byte, single pulse
    applyStimulus(1, 8'h3C, 1, 0, 0);
    firstTick = -1; tickCount = 0;
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk);
      if (idle_tick) begin tickCount++; if (firstTick < 0) firstTick = k; end
      @(posedge clk); #1;
    end
    checkOutput("idle tick time", firstTick, IDLE);
    checkOutput("idle tick count", tickCount, 1);

    // rx_busy at cycle 500 restarts the idle count
    applyStimulus(1, 8'hC3, 1, 0, 0);
    firstTick = -1; tickCount = 0;
    for (int k = 1; k <= 1600; k++) begin
      rx_busy = (k == 500);
      @(negedge clk);
      if (idle_tick) begin tickCount++; if (firstTick < 0) firstTick = k; end
      @(posedge clk); #1;
    end
    rx_busy = 1'b0;
    checkOutput("idle busy restart time", firstTick, 500 + IDLE);
    checkOutput("idle busy tick count", tickCount, 1);

    // Randomized traffic with random backpressure and clears
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 9) < 4, 8'($urandom), 1'($urandom_range(0, 1)),
                    0, $urandom_range(0, 19) == 0);
    m_ready = 1'b1;
    idleCycles(DEPTH + 4);
    applyStimulus(0, 8'h00, 1, 0, 1);
    idleCycles(2);
    checkOutput("random scoreboard empty", expQ.size(), 0);

`ifdef UART_RX_CTRL_STATS_EN
    checkOutput("stats byte_cnt", byte_cnt, 16'(expBytes));
    checkOutput("stats err_cnt", err_cnt, (expErrs > 255) ? 255 : expErrs);
    checkOutput("stats drop_cnt", drop_cnt, (expDrops > 255) ? 255 : expDrops);
`endif

    // Reset mid-frame with three bytes buffered
    for (int i = 0; i < 3; i++) applyStimulus(1, 8'(8'h70 + i), 0, 0, 0);
    rx_busy = 1'b1;
    #2;
    rst_n = 1'b0;
    expQ.delete(); expOverrun = 1'b0; inRun = 1'b0;
    enable = 1'b0; rx_busy = 1'b0;
    #1;
    checkOutput("mid reset rx_en", rx_en, 0);
    checkOutput("mid reset m_valid", m_valid, 0);
    checkOutput("mid reset level", level, 0);
    checkOutput("mid reset overrun", overrun, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); checkOutput("post reset off rx_en", rx_en, 0);
      @(posedge clk); #1;
    end
`ifdef UART_RX_CTRL_STATS_EN
    checkOutput("post reset byte_cnt", byte_cnt, 0);
`endif
    enableAndWait();
    applyStimulus(1, 8'h5A, 1, 0, 0);
    idleCycles(4);
    checkOutput("post reset drained", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller sitting between the 8-bit oversampled UART receiver and the system side. It sequences the receiver's enable: arm on request, and forced re-arm with holdoff after a frame/start-bit error. It captures each completed byte into a small FIFO exposed as a valid/ready stream. It also flags overrun and idle-line timeout.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2.
ERR_HOLDOFF, 16, clk cycles the receiver is held disabled after an error; at least 1.
IDLE_TIMEOUT, 1024, clk cycles of line idle after the last byte before idle_tick fires; at least 2.

Ports:
clk  in  1  receiver oversample clock (16x baud), same clock as receiver.
rst_n  in  1  asynchronous active-low reset.
enable  in  1  software enable for reception.
rx_en  out  1  drives receiver en.
rx_data  in  8  receiver out; valid only while rx_done=1.
rx_done  in  1  receiver one-cycle byte-complete pulse.
rx_busy  in  1  receiver frame in progress.
rx_err  in  1  receiver error flag.
m_data  out  8  head-of-FIFO byte.
m_valid  out  1  FIFO non-empty.
m_ready  in  1  consumer accepts m_data when m_valid and m_ready are both 1.
overrun  out  1  sticky; a byte was dropped because the FIFO was full.
overrun_clr  in  1  clears overrun.
idle_tick  out  1  one-cycle pulse on idle timeout.
level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state OFF, rx_en=0, FIFO empty, m_valid=0, m_data=0, overrun=0, idle_tick=0, level=0, all counters 0.
- States:
  - OFF: rx_en=0. If enable=1, go to ARM.
  - ARM: rx_en=1. Next cycle go to RUN; the receiver needs one cycle in its RESET state.
  - RUN: rx_en=1.
    - rx_err=1: go to HOLD, load the holdoff counter with ERR_HOLDOFF-1, drop any rx_done in the same cycle.
    - Otherwise rx_done=1: push rx_data.
  - HOLD: rx_en=0. Decrement the counter. At 0, go to ARM; if enable=0 instead, go to OFF.
- enable=0 in any state: next state OFF, rx_en=0 next cycle. A frame in flight is abandoned. The FIFO contents are kept.
- rx_en is registered: its value follows the state one cycle after the transition.
- FIFO:
  - Push on accepted rx_done; pop on m_valid && m_ready.
  - m_data is the registered head, with zero-cycle read latency: valid in the same cycle as m_valid.
  - Pointers wrap modulo DEPTH.
- Full with push and no pop: byte dropped, overrun set the next cycle, FIFO unchanged.
- Full with push and pop in the same cycle: both take effect, level stays DEPTH, no overrun.
- Empty with push and pop in the same cycle: pop is ignored (m_valid was 0), push takes effect.
- overrun_clr and a new overrun in the same cycle: overrun ends at 1 (set wins).
- m_data and m_valid are stable while m_valid=1 && m_ready=0.
- Idle counter:
  - Runs only in RUN with rx_busy=0, after at least one byte has been received since the last idle_tick or arm.
  - Cleared on rx_busy=1, rx_done=1, or leaving RUN.
  - On reaching IDLE_TIMEOUT-1: idle_tick=1 for one cycle, then disarmed until the next accepted byte.
- Width rules: level saturates naturally at DEPTH. All counters are unsigned with no wrap (holdoff and idle counters stop at their terminal values).

Optional Feature:
UART_RX_CTRL_STATS_EN.
- Defined:
  - Adds output byte_cnt (16 bit): bytes pushed, wraps at 65535->0.
  - Adds output err_cnt (8 bit): RUN->HOLD transitions, saturates at 255.
  - Adds output drop_cnt (8 bit): overrun drops, saturates at 255.
  - All three reset to 0 on rst_n only.
- Not defined: these ports and registers are absent; other behaviour is identical.

Decomposition:
- Shared package/header uart_pkg:
  - Controller state encodings (OFF=0, ARM=1, RUN=2, HOLD=3, 2-bit).
  - Data width constant 8.
- One sub-module: uart_sync_fifo.
  - Parameter DEPTH, 8-bit data.
  - Ports: push/pop/full/empty/level.
  - Async active-low reset; head register output.

Test Plan:
1. Reset then enable=1: rx_en is 0, then 1 two cycles after enable rises (OFF->ARM->RUN). Three rx_done pulses with 0x55, 0xA3, 0x00 and m_ready=1 -> m_data sequence 0x55, 0xA3, 0x00, level returns to 0, overrun=0.
2. DEPTH=8, m_ready=0, 9 rx_done pulses with 0x01..0x09 -> level=8, overrun=1 after the 9th. Drain -> 0x01..0x08. overrun_clr -> overrun=0.
3. FIFO full, rx_done together with m_ready=1 -> level stays 8, new byte is at the tail, overrun stays 0.
4. rx_err=1 in RUN -> rx_en=0 for exactly ERR_HOLDOFF=16 cycles, then ARM, then rx_en=1. A simultaneous rx_done byte is not pushed. With STATS_EN, err_cnt=1.
5. One byte received, then line idle with rx_busy=0 -> idle_tick single pulse exactly IDLE_TIMEOUT cycles after rx_done, no second pulse until the next byte. rx_busy asserted at cycle 500 restarts the count.
6. rst_n asserted mid-frame with the FIFO holding 3 bytes -> immediately rx_en=0, m_valid=0, level=0, overrun=0. After release, state is OFF until enable is seen.
